// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: DEPTH-entry prefetch queue in front of a 1-cycle-latency
// instruction memory. Keeps fetching through ID stalls and flushes on taken branches.
module if_prefetch_stage #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        PC_STEP  = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               is_branch,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  pc_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(DEPTH);

  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc    [DEPTH];

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_addr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              inflight;
  logic              inflight_epoch;
  logic              epoch;

  logic [OCC_W-1:0]  occupancy_c;
  logic              push_c;
  logic              pop_c;

  // Credit rule: queued entries plus the outstanding response never exceed DEPTH.
  assign occupancy_c = {1'b0, count} + OCC_W'(inflight);
  assign imem_req    = !rst && (occupancy_c < DEPTH_C);
  assign imem_addr   = fetch_pc;

  // A branch flushes the queue, so it overrides both push and pop this cycle.
  assign push_c = inflight && (inflight_epoch == epoch) && !is_branch;
  assign pop_c  = valid_out && !freeze && !is_branch;

  assign valid_out       = (count != '0);
  assign instruction_out = valid_out ? q_instr[rd_ptr] : '0;
  assign pc_out          = valid_out ? (q_pc[rd_ptr] + STEP) : '0;

  // Control state: fetch PC, pointers, occupancy, in-flight tracking and epoch.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight_addr  <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc       <= fetch_pc + STEP;
        inflight_addr  <= fetch_pc;
        inflight_epoch <= epoch;
      end
      if (is_branch) begin
        fetch_pc <= branch_address;
        epoch    <= ~epoch;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
      end
    end
  end

  // Queue storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= inflight_addr;
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: fill, freeze, branch flush, wrap and reset.
module tb_if_prefetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, freeze, is_branch;
  logic [31:0] branch_address;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, imem_rdata, instruction_out, pc_out;

  logic        rst_w, freeze_w, is_branch_w;
  logic [31:0] branch_address_w;
  logic        imem_req_w, valid_out_w;
  logic [31:0] imem_addr_w, imem_rdata_w, instruction_out_w, pc_out_w;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_a;

  if_prefetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .is_branch(is_branch),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .valid_out(valid_out),
    .instruction_out(instruction_out), .pc_out(pc_out)
  );

  if_prefetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst_w), .freeze(freeze_w), .is_branch(is_branch_w),
    .branch_address(branch_address_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .valid_out(valid_out_w),
    .instruction_out(instruction_out_w), .pc_out(pc_out_w)
  );

  // Synchronous instruction memories: data = addr ^ KEY one cycle after the request.
  always @(posedge clk) if (imem_req)   imem_rdata   <= imem_addr ^ KEY;
  always @(posedge clk) if (imem_req_w) imem_rdata_w <= imem_addr_w ^ KEY;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; is_branch = 1'b0; branch_address = '0;
    tick(); tick();
    tests++;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req_held: got %0b want 0", imem_req); end
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid_held: got %0b want 0", valid_out); end
    rst = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin fails++; $display("FAIL reset_issue: got req=%0b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    tests++;
    if (valid_out !== 1'b0 || instruction_out !== 32'h0 || pc_out !== 32'h0)
      begin fails++; $display("FAIL reset_outputs: got v=%0b i=%h pc=%h want 0/0/0", valid_out, instruction_out, pc_out); end
  endtask

  task automatic test_fill();
    sb.delete();
    for (int i = 0; i < 12; i++) sb.push_back(32'(4 * i));
    for (int c = 0; c < 14; c++) begin
      if (c < 2) begin
        tests++;
        if (valid_out !== 1'b0) begin fails++; $display("FAIL fill_latency c%0d: got v=%0b want 0", c, valid_out); end
      end else begin
        exp_a = sb.pop_front();
        tests++;
        if (valid_out !== 1'b1 || instruction_out !== (exp_a ^ KEY) || pc_out !== exp_a + 32'd4)
          begin fails++; $display("FAIL fill_stream c%0d: got v=%0b i=%h pc=%h want v=1 i=%h pc=%h",
                                  c, valid_out, instruction_out, pc_out, exp_a ^ KEY, exp_a + 32'd4); end
      end
      tick();
    end
  endtask

  task automatic test_freeze_fill();
    freeze = 1'b0;
    do_reset();
    tick(); tick();
    freeze = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tests++;
      if (valid_out !== 1'b1 || instruction_out !== KEY || pc_out !== 32'd4)
        begin fails++; $display("FAIL freeze_head c%0d: got v=%0b i=%h pc=%h want v=1 i=%h pc=4",
                                c, valid_out, instruction_out, pc_out, KEY); end
      tests++;
      if (imem_req !== (c < 2))
        begin fails++; $display("FAIL freeze_credit c%0d: got req=%0b want %0b", c, imem_req, (c < 2)); end
      tick();
    end
    freeze = 1'b0;
    sb.delete();
    for (int i = 0; i < 5; i++) sb.push_back(32'(4 * i));
    for (int c = 0; c < 5; c++) begin
      exp_a = sb.pop_front();
      tests++;
      if (valid_out !== 1'b1 || instruction_out !== (exp_a ^ KEY) || pc_out !== exp_a + 32'd4)
        begin fails++; $display("FAIL freeze_release c%0d: got v=%0b pc=%h want v=1 pc=%h",
                                c, valid_out, pc_out, exp_a + 32'd4); end
      tick();
    end
  endtask

  task automatic test_branch();
    freeze = 1'b1;
    do_reset();
    tick(); tick(); tick(); tick();
    is_branch = 1'b1; branch_address = 32'h100;
    tick();
    is_branch = 1'b0; freeze = 1'b0;
    tests++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      begin fails++; $display("FAIL branch_redirect: got v=%0b req=%0b addr=%h want 0/1/100",
                              valid_out, imem_req, imem_addr); end
    tick();
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL branch_bubble: got v=%0b want 0", valid_out); end
    tick();
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(4 * i));
    for (int c = 0; c < 4; c++) begin
      exp_a = sb.pop_front();
      tests++;
      if (valid_out !== 1'b1 || instruction_out !== (exp_a ^ KEY) || pc_out !== exp_a + 32'd4)
        begin fails++; $display("FAIL branch_stream c%0d: got v=%0b i=%h pc=%h want i=%h pc=%h",
                                c, valid_out, instruction_out, pc_out, exp_a ^ KEY, exp_a + 32'd4); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    freeze = 1'b1;
    do_reset();
    tick(); tick();
    is_branch = 1'b1; branch_address = 32'h200;
    tick();
    branch_address = 32'h300;
    tests++;
    if (valid_out !== 1'b0 || imem_addr !== 32'h200)
      begin fails++; $display("FAIL b2b_first: got v=%0b addr=%h want 0/200", valid_out, imem_addr); end
    tick();
    is_branch = 1'b0;
    tests++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300)
      begin fails++; $display("FAIL b2b_second: got v=%0b req=%0b addr=%h want 0/1/300",
                              valid_out, imem_req, imem_addr); end
    tick();
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL b2b_bubble: got v=%0b want 0", valid_out); end
    tick();
    for (int c = 0; c < 2; c++) begin
      tests++;
      if (valid_out !== 1'b1 || instruction_out !== (32'h300 ^ KEY) || pc_out !== 32'h304)
        begin fails++; $display("FAIL b2b_head c%0d: got v=%0b i=%h pc=%h want v=1 pc=304",
                                c, valid_out, instruction_out, pc_out); end
      tick();
    end
    freeze = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(32'h300 + 32'(4 * i));
    for (int c = 0; c < 4; c++) begin
      exp_a = sb.pop_front();
      tests++;
      if (valid_out !== 1'b1 || pc_out !== exp_a + 32'd4)
        begin fails++; $display("FAIL b2b_stream c%0d: got v=%0b pc=%h want pc=%h",
                                c, valid_out, pc_out, exp_a + 32'd4); end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    freeze = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (valid_out !== 1'b1) begin fails++; $display("FAIL midrun_prefill: got v=%0b want 1", valid_out); end
    rst = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL midrun_req_in_reset: got %0b want 0", imem_req); end
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin fails++; $display("FAIL midrun_after: got v=%0b req=%0b addr=%h want 0/1/0",
                              valid_out, imem_req, imem_addr); end
    tick();
    tests++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL midrun_stale: got v=%0b pc=%h want v=0", valid_out, pc_out); end
    tick();
    freeze = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back(32'(4 * i));
    for (int c = 0; c < 3; c++) begin
      exp_a = sb.pop_front();
      tests++;
      if (valid_out !== 1'b1 || instruction_out !== (exp_a ^ KEY) || pc_out !== exp_a + 32'd4)
        begin fails++; $display("FAIL midrun_stream c%0d: got v=%0b i=%h pc=%h want pc=%h",
                                c, valid_out, instruction_out, pc_out, exp_a + 32'd4); end
      tick();
    end
  endtask

  task automatic test_wrap();
    tick();
    rst_w = 1'b0;
    #1;
    tests++;
    if (imem_addr_w !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_addr0: got %h want fffffff8", imem_addr_w); end
    tick();
    tests++;
    if (imem_addr_w !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr1: got %h want fffffffc", imem_addr_w); end
    tick();
    tests++;
    if (imem_addr_w !== 32'h0) begin fails++; $display("FAIL wrap_addr2: got %h want 0", imem_addr_w); end
    sb.delete();
    sb.push_back(32'hFFFF_FFF8); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
    for (int c = 0; c < 3; c++) begin
      exp_a = sb.pop_front();
      tests++;
      if (valid_out_w !== 1'b1 || instruction_out_w !== (exp_a ^ KEY) || pc_out_w !== exp_a + 32'd4)
        begin fails++; $display("FAIL wrap_stream c%0d: got v=%0b i=%h pc=%h want i=%h pc=%h",
                                c, valid_out_w, instruction_out_w, pc_out_w, exp_a ^ KEY, exp_a + 32'd4); end
      tick();
    end
  endtask

  initial begin
    rst_w = 1'b1; freeze_w = 1'b0; is_branch_w = 1'b0; branch_address_w = '0;
    test_reset();
    test_fill();
    test_freeze_fill();
    test_branch();
    test_back_to_back();
    test_reset_midrun();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal finish");
    $fatal(1, "watchdog expired");
  end

endmodule
